// File: rtl/cpu_decode_pkg.sv
// rtl/cpu_decode_pkg.sv - shared field widths, decode FSM encoding and sign-extend helper
package cpu_decode_pkg;

  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_OPCODE_WIDTH    = 4;
  localparam int unsigned DEF_REG_INDEX_WIDTH = 5;
  // Two flag bits (immFlag, longImm) sit between the opcode and the register fields.
  localparam int unsigned FLAG_BITS           = 2;
  localparam int unsigned DEF_IMM_WIDTH       =
    DEF_DATA_WIDTH - DEF_OPCODE_WIDTH - FLAG_BITS - 2 * DEF_REG_INDEX_WIDTH;

  typedef enum logic {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } dec_state_e;

  function automatic logic [63:0] sign_extend(input logic [63:0] raw, input int unsigned width);
    logic [63:0] mask;
    logic        sign_bit;
    mask     = (64'd1 << width) - 64'd1;
    sign_bit = |((raw >> (width - 1)) & 64'd1);
    return sign_bit ? (raw | ~mask) : (raw & mask);
  endfunction

endpackage

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational instruction field split and immediate sign-extension
module decode_fields
  import cpu_decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned OPCODE_WIDTH    = DEF_OPCODE_WIDTH,
  parameter int unsigned REG_INDEX_WIDTH = DEF_REG_INDEX_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]      ir,
  output logic [OPCODE_WIDTH-1:0]    opcode,
  output logic                       imm_flag,
  output logic                       long_imm,
  output logic [REG_INDEX_WIDTH-1:0] dest,
  output logic [REG_INDEX_WIDTH-1:0] src,
  output logic [DATA_WIDTH-1:0]      imm_ext
);

  localparam int unsigned IMM_WIDTH = DATA_WIDTH - OPCODE_WIDTH - FLAG_BITS - 2 * REG_INDEX_WIDTH;
  localparam int unsigned DEST_MSB  = DATA_WIDTH - OPCODE_WIDTH - FLAG_BITS - 1;
  localparam int unsigned SRC_MSB   = DEST_MSB - REG_INDEX_WIDTH;

  logic [IMM_WIDTH-1:0] imm_raw;

  assign opcode   = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign imm_flag = ir[DATA_WIDTH-OPCODE_WIDTH-1];
  assign long_imm = ir[DATA_WIDTH-OPCODE_WIDTH-2];
  assign dest     = ir[DEST_MSB -: REG_INDEX_WIDTH];
  assign src      = ir[SRC_MSB -: REG_INDEX_WIDTH];
  assign imm_raw  = ir[IMM_WIDTH-1:0];
  assign imm_ext  = DATA_WIDTH'(sign_extend(64'(imm_raw), IMM_WIDTH));

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - registered decode stage with handshake and two-word long immediates
module instruction_decode_stage
  import cpu_decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned OPCODE_WIDTH    = DEF_OPCODE_WIDTH,
  parameter int unsigned REG_INDEX_WIDTH = DEF_REG_INDEX_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] MAX_LEGAL_OPCODE = 'hD
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      IR,
  input  logic                       inValid,
  output logic                       inReady,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [OPCODE_WIDTH-1:0]    ALUOperationCode,
  output logic [REG_INDEX_WIDTH-1:0] destination,
  output logic [REG_INDEX_WIDTH-1:0] source,
  output logic [DATA_WIDTH-1:0]      immediate,
  output logic                       isSecondImmediate,
  output logic                       illegalInstruction,
  output logic                       longPending
);

  logic [OPCODE_WIDTH-1:0]    fld_opcode;
  logic                       fld_imm_flag;
  logic                       fld_long_imm;
  logic [REG_INDEX_WIDTH-1:0] fld_dest;
  logic [REG_INDEX_WIDTH-1:0] fld_src;
  logic [DATA_WIDTH-1:0]      fld_imm;
  logic                       fld_illegal;

  decode_fields #(
    .DATA_WIDTH     (DATA_WIDTH),
    .OPCODE_WIDTH   (OPCODE_WIDTH),
    .REG_INDEX_WIDTH(REG_INDEX_WIDTH)
  ) u_decode_fields (
    .ir      (IR),
    .opcode  (fld_opcode),
    .imm_flag(fld_imm_flag),
    .long_imm(fld_long_imm),
    .dest    (fld_dest),
    .src     (fld_src),
    .imm_ext (fld_imm)
  );

  assign fld_illegal = fld_opcode > MAX_LEGAL_OPCODE;

  dec_state_e                 state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic                       long_pending_q, long_pending_d;
  logic [OPCODE_WIDTH-1:0]    op_q, op_d;
  logic [REG_INDEX_WIDTH-1:0] dest_q, dest_d;
  logic [REG_INDEX_WIDTH-1:0] src_q, src_d;
  logic [DATA_WIDTH-1:0]      imm_q, imm_d;
  logic                       is_imm_q, is_imm_d;
  logic                       illegal_q, illegal_d;
  // First word of a long-immediate instruction, held until its immediate word arrives.
  logic [OPCODE_WIDTH-1:0]    lat_op_q, lat_op_d;
  logic [REG_INDEX_WIDTH-1:0] lat_dest_q, lat_dest_d;
  logic [REG_INDEX_WIDTH-1:0] lat_src_q, lat_src_d;
  logic                       lat_illegal_q, lat_illegal_d;

  logic in_ready;
  logic accept;

  assign in_ready = !flush && (!out_valid_q || outReady);
  assign accept   = inValid && in_ready;

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    long_pending_d = long_pending_q;
    op_d           = op_q;
    dest_d         = dest_q;
    src_d          = src_q;
    imm_d          = imm_q;
    is_imm_d       = is_imm_q;
    illegal_d      = illegal_q;
    lat_op_d       = lat_op_q;
    lat_dest_d     = lat_dest_q;
    lat_src_d      = lat_src_q;
    lat_illegal_d  = lat_illegal_q;

    if (flush) begin
      state_d        = WAIT_FIRST;
      out_valid_d    = 1'b0;
      long_pending_d = 1'b0;
    end else begin
      if (out_valid_q && outReady) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        unique case (state_q)
          WAIT_FIRST: begin
            if (fld_long_imm) begin
              lat_op_d       = fld_opcode;
              lat_dest_d     = fld_dest;
              lat_src_d      = fld_src;
              lat_illegal_d  = fld_illegal;
              long_pending_d = 1'b1;
              state_d        = WAIT_SECOND;
            end else begin
              op_d        = fld_opcode;
              dest_d      = fld_dest;
              src_d       = fld_src;
              imm_d       = fld_imm;
              is_imm_d    = fld_imm_flag;
              illegal_d   = fld_illegal;
              out_valid_d = 1'b1;
            end
          end
          WAIT_SECOND: begin
            op_d           = lat_op_q;
            dest_d         = lat_dest_q;
            src_d          = lat_src_q;
            imm_d          = IR;
            is_imm_d       = 1'b1;
            illegal_d      = lat_illegal_q;
            out_valid_d    = 1'b1;
            long_pending_d = 1'b0;
            state_d        = WAIT_FIRST;
          end
          default: state_d = WAIT_FIRST;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= WAIT_FIRST;
      out_valid_q    <= 1'b0;
      long_pending_q <= 1'b0;
      op_q           <= '0;
      dest_q         <= '0;
      src_q          <= '0;
      imm_q          <= '0;
      is_imm_q       <= 1'b0;
      illegal_q      <= 1'b0;
      lat_op_q       <= '0;
      lat_dest_q     <= '0;
      lat_src_q      <= '0;
      lat_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      long_pending_q <= long_pending_d;
      op_q           <= op_d;
      dest_q         <= dest_d;
      src_q          <= src_d;
      imm_q          <= imm_d;
      is_imm_q       <= is_imm_d;
      illegal_q      <= illegal_d;
      lat_op_q       <= lat_op_d;
      lat_dest_q     <= lat_dest_d;
      lat_src_q      <= lat_src_d;
      lat_illegal_q  <= lat_illegal_d;
    end
  end

  assign inReady            = in_ready;
  assign outValid           = out_valid_q;
  assign longPending        = long_pending_q;
  assign ALUOperationCode   = op_q;
  assign destination        = dest_q;
  assign source             = src_q;
  assign immediate          = imm_q;
  assign isSecondImmediate  = is_imm_q;
  assign illegalInstruction = illegal_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - self-checking bench for instruction_decode_stage
module tb_instruction_decode_stage;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] IR;
  logic        inValid;
  logic        inReady;
  logic        outValid;
  logic        outReady;
  logic [3:0]  ALUOperationCode;
  logic [4:0]  destination;
  logic [4:0]  source;
  logic [31:0] immediate;
  logic        isSecondImmediate;
  logic        illegalInstruction;
  logic        longPending;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_decode_stage dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .IR                (IR),
    .inValid           (inValid),
    .inReady           (inReady),
    .outValid          (outValid),
    .outReady          (outReady),
    .ALUOperationCode  (ALUOperationCode),
    .destination       (destination),
    .source            (source),
    .immediate         (immediate),
    .isSecondImmediate (isSecondImmediate),
    .illegalInstruction(illegalInstruction),
    .longPending       (longPending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic [4:0]  src;
    logic [31:0] imm;
    logic        is_imm;
    logic        ill;
  } vec_t;

  typedef struct {
    int unsigned op;
    int unsigned dest;
    int unsigned src;
    logic [31:0] imm;
    bit          is_imm;
    bit          ill;
    bit          long_imm;
  } dec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] word);
    IR       = word;
    inValid  = 1'b1;
    outReady = 1'b1;
    step();
    inValid  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] op, input logic [4:0] d,
                         input logic [4:0] s, input logic [31:0] imm, input logic is_imm,
                         input logic ill);
    chk({tag, ".valid"},   32'(outValid), 32'd1);
    chk({tag, ".op"},      32'(ALUOperationCode), 32'(op));
    chk({tag, ".dest"},    32'(destination), 32'(d));
    chk({tag, ".src"},     32'(source), 32'(s));
    chk({tag, ".imm"},     immediate, imm);
    chk({tag, ".is_imm"},  32'(isSecondImmediate), 32'(is_imm));
    chk({tag, ".illegal"}, 32'(illegalInstruction), 32'(ill));
  endtask

  // Field meaning taken from the documented layout, using plain arithmetic.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t r;
    int unsigned u;
    int unsigned low;
    u          = w;
    r.op       = u / 32'h1000_0000;
    r.is_imm   = ((u / (1 << 27)) % 2) == 1;
    r.long_imm = ((u / (1 << 26)) % 2) == 1;
    r.dest     = (u / (1 << 21)) % 32;
    r.src      = (u / (1 << 16)) % 32;
    low        = u % 65536;
    r.imm      = (low >= 32768) ? (low + 32'hFFFF_0000) : low;
    r.ill      = r.op > 13;
    return r;
  endfunction

  vec_t vecs[5];

  bit          m_valid;
  bit          m_pend;
  dec_t        m_out;
  dec_t        m_held;
  bit          exp_ready;
  dec_t        d;

  initial begin
    vecs[0] = '{32'h3A2A_FFFE, 4'd3,  5'd17, 5'd10, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[1] = '{32'hE000_0001, 4'd14, 5'd0,  5'd0,  32'h0000_0001, 1'b0, 1'b1};
    vecs[2] = '{32'h1000_7FFF, 4'd1,  5'd0,  5'd0,  32'h0000_7FFF, 1'b0, 1'b0};
    vecs[3] = '{32'hD800_8000, 4'd13, 5'd0,  5'd0,  32'hFFFF_8000, 1'b1, 1'b0};
    vecs[4] = '{32'hF3FF_0000, 4'd15, 5'd31, 5'd31, 32'h0000_0000, 1'b0, 1'b1};

    reset    = 1'b0;
    flush    = 1'b0;
    IR       = 32'h0;
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (2) step();
    chk("rst.valid",   32'(outValid), 32'd0);
    chk("rst.pending", 32'(longPending), 32'd0);
    chk("rst.op",      32'(ALUOperationCode), 32'd0);
    chk("rst.imm",     immediate, 32'd0);
    chk("rst.flags",   32'({isSecondImmediate, illegalInstruction, destination, source}), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst.in_ready", 32'(inReady), 32'd1);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].ir);
      chk_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].dest, vecs[i].src,
              vecs[i].imm, vecs[i].is_imm, vecs[i].ill);
    end

    send(32'h5C22_0000);
    chk("long1.valid",   32'(outValid), 32'd0);
    chk("long1.pending", 32'(longPending), 32'd1);
    send(32'hDEAD_BEEF);
    chk_out("long2", 4'd5, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("long2.pending", 32'(longPending), 32'd0);

    IR       = 32'h3A2A_FFFE;
    inValid  = 1'b1;
    outReady = 1'b0;
    #1;
    chk("stall.in_ready", 32'(inReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall.hold", 4'd5, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b1, 1'b0);
      chk("stall.in_ready", 32'(inReady), 32'd0);
    end
    outReady = 1'b1;
    #1;
    chk("release.in_ready", 32'(inReady), 32'd1);
    step();
    inValid = 1'b0;
    chk_out("release", 4'd3, 5'd17, 5'd10, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step();
    chk("drain.valid", 32'(outValid), 32'd0);

    send(32'h5C22_0000);
    chk("flush.pre_pending", 32'(longPending), 32'd1);
    flush   = 1'b1;
    inValid = 1'b1;
    IR      = 32'h1234_5678;
    #1;
    chk("flush.in_ready", 32'(inReady), 32'd0);
    step();
    flush   = 1'b0;
    inValid = 1'b0;
    chk("flush.pending", 32'(longPending), 32'd0);
    chk("flush.valid",   32'(outValid), 32'd0);
    send(32'h3A2A_FFFE);
    chk_out("after_flush", 4'd3, 5'd17, 5'd10, 32'hFFFF_FFFE, 1'b1, 1'b0);

    send(32'h5C22_0000);
    reset   = 1'b0;
    inValid = 1'b1;
    IR      = 32'hDEAD_BEEF;
    step();
    reset   = 1'b1;
    inValid = 1'b0;
    chk("midrst.pending", 32'(longPending), 32'd0);
    chk("midrst.valid",   32'(outValid), 32'd0);
    chk("midrst.imm",     immediate, 32'd0);
    send(32'h3A2A_FFFE);
    chk_out("after_rst", 4'd3, 5'd17, 5'd10, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step();
    chk("idle.valid", 32'(outValid), 32'd0);

    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_out   = '{default: 0};
    m_held  = '{default: 0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush    = ($urandom_range(0, 15) == 0);
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      IR       = $urandom;
      exp_ready = !flush && (!m_valid || outReady);
      #1;
      chk("rnd.in_ready", 32'(inReady), 32'(exp_ready));
      @(posedge clock);
      if (flush) begin
        m_valid = 1'b0;
        m_pend  = 1'b0;
      end else begin
        if (m_valid && outReady) m_valid = 1'b0;
        if (inValid && exp_ready) begin
          d = ref_decode(IR);
          if (m_pend) begin
            m_out        = m_held;
            m_out.imm    = IR;
            m_out.is_imm = 1'b1;
            m_valid      = 1'b1;
            m_pend       = 1'b0;
          end else if (d.long_imm) begin
            m_held = d;
            m_pend = 1'b1;
          end else begin
            m_out   = d;
            m_valid = 1'b1;
          end
        end
      end
      #1;
      chk("rnd.valid",   32'(outValid), 32'(m_valid));
      chk("rnd.pending", 32'(longPending), 32'(m_pend));
      if (m_valid) begin
        chk("rnd.op",      32'(ALUOperationCode), m_out.op);
        chk("rnd.dest",    32'(destination), m_out.dest);
        chk("rnd.src",     32'(source), m_out.src);
        chk("rnd.imm",     immediate, m_out.imm);
        chk("rnd.is_imm",  32'(isSecondImmediate), 32'(m_out.is_imm));
        chk("rnd.illegal", 32'(illegalInstruction), 32'(m_out.ill));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
